mips_fetch_unit: RTL
====================

// Module: mips_fetch_unit
// PURPOSE
//  Holds PC, IR and MDR for the multicycle MIPS core. Executes the memory accesses commanded by control_module.
//  Runs a valid/ready handshake with the unified instruction/data memory.
//  Selects and commits next-PC. Decodes IR fields: Op_code and Funct go back to control; the rest go to the datapath.
//  Asserts stall while a memory access is outstanding; control holds its state while stall=1.
// PARAMETERS
//  N          32       datapath/address width
//  RESET_PC   32'h0    PC value after reset
//  TIMEOUT    255      max wait cycles for mem_ready before mem_err (8-bit counter)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  IRWrite    in   1   fetch: read mem[PC] into IR
//  IorD       in   1   0: address=PC, 1: address=alu_out
//  MemWrite   in   1   data store of reg_b to mem[alu_out]
//  MemRead    in   1   data load of mem[alu_out] into MDR (IorD=1)
//  PCWrite    in   1   unconditional PC commit
//  PCWriteCond in  1   commit PC if alu_zero
//  PCSource   in   2   00 alu_result, 01 alu_out, 10 jump target, 11 hold PC
//  alu_result in   N   combinational ALU output
//  alu_out    in   N   registered ALU output
//  alu_zero   in   1   ALU zero flag
//  reg_b      in   N   store data
//  mem_req    out  1   access request, held until mem_ready
//  mem_we     out  1   1=write, stable while mem_req
//  mem_addr   out  N   address, stable while mem_req
//  mem_wdata  out  N   write data, stable while mem_req
//  mem_ready  in   1   1-cycle completion strobe; mem_rdata valid same cycle
//  mem_rdata  in   N   read data
//  stall      out  1   access outstanding
//  mem_err    out  1   sticky timeout flag; cleared only by rst
//  pc         out  N   current PC
//  ir         out  N   instruction register
//  mdr        out  N   memory data register
//  Op_code    out  6   ir[31:26]
//  Funct      out  6   ir[5:0]
//  rs, rt, rd out  5   ir[25:21], ir[20:16], ir[15:11]
//  shamt      out  5   ir[10:6]
//  imm_sext   out  N   sign-extended ir[15:0]
// BEHAVIOUR
//  Reset: pc=RESET_PC; ir, mdr=0; mem_req, mem_we, stall, mem_err=0; counter=0; FSM=IDLE.
//  FSM IDLE: an access starts on IRWrite | MemRead | MemWrite.
//    On start: latch addr, we and wdata; mem_req=1; go to BUSY. stall is combinationally 1 in the start cycle too.
//  FSM BUSY: mem_req=1, stall=1, counter increments.
//    mem_ready=1: capture rdata (IR if fetch, MDR if load); drop mem_req; commit any pending PC update; go to IDLE.
//    counter==TIMEOUT: set mem_err; abort (mem_req=0); go to IDLE; IR/MDR/PC unchanged.
//  Access priority on simultaneous requests: MemWrite > MemRead > IRWrite. The lower ones are ignored that cycle.
//  PC update: en = PCWrite | (PCWriteCond & alu_zero).
//    No access starting: commit next_pc at the clock edge (latency 1).
//    Fetch starting: PCWrite is latched as pending. PC and IR commit together on the mem_ready edge.
//    Fetch PC+4 comes from alu_result at request time; it is latched as pending_pc.
//  Jump target = {pc[N-1:28], ir[25:0], 2'b00}, computed from the current (already incremented) pc.
//  PCSource=11 or en=0: pc holds.
//  mem_ready while IDLE is ignored. Control inputs while BUSY are ignored; they are not queued.
//  Field outputs are combinational from ir; they change 0 cycles after an IR update.
//  rst mid-access: FSM=IDLE, mem_req drops asynchronously, pending PC update is discarded.
// CONFIGURATION
//  INSTR_COUNT_EN defined:
//    adds output instr_count [31:0], reset 0, +1 on each completed fetch, wraps 2^32-1 -> 0.
//  INSTR_COUNT_EN undefined: port and counter are absent.
// STRUCTURE
//  Shared package/defines mips_core_defines.v:
//    FSM state encodings, PCSource encodings (PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_HOLD), N, RESET_PC.
//  Sub-module mem_handshake_fsm: IDLE/BUSY, timeout counter, latched request, mem_err.
//  Top level holds the PC/IR/MDR registers, next-PC mux and field decode.
// TESTING
//  Reset, then fetch: mem_ready after 3 cycles with rdata=32'h2008_0005
//    -> stall high 3 cycles; IR=32'h2008_0005; pc=4 on same edge; Op_code=6'h08.
//  Branch: PCWriteCond=1, alu_zero=1, PCSource=01, alu_out=32'h40 -> pc=32'h40 next edge.
//    Same stimulus with alu_zero=0 -> pc unchanged.
//  Jump: pc=32'h1000_0004, ir=32'h0800_0010, PCSource=10, PCWrite=1 -> pc=32'h1000_0040.
//  Store then load: MemWrite, alu_out=8, reg_b=32'hDEAD_BEEF -> mem_we=1, mem_addr=8.
//    Then MemRead at addr 8 -> mdr=32'hDEAD_BEEF.
//  Timeout: fetch with mem_ready held 0 -> mem_err=1 after 255 BUSY cycles; IR and pc unchanged; mem_err stays 1.
//  rst asserted in 2nd BUSY cycle -> mem_req=0 immediately; pc=RESET_PC; a late mem_ready is ignored.
//    With INSTR_COUNT_EN, 3 fetches -> instr_count=3.

Source files
------------

// File: rtl/mips_fetch_unit_pkg.sv
// mips_fetch_unit_pkg: shared encodings and defaults for the multicycle MIPS fetch unit
package mips_fetch_unit_pkg;
  localparam int MFU_N = 32;
  localparam logic [31:0] MFU_RESET_PC = 32'h0;
  localparam int unsigned MFU_TIMEOUT = 255;
  typedef enum logic {IDLE, BUSY} hs_state_t;
  typedef enum logic [1:0] {ACC_FETCH, ACC_LOAD, ACC_STORE} acc_t;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;
  function automatic acc_t acc_sel(input logic store, input logic load);
    return store ? ACC_STORE : load ? ACC_LOAD : ACC_FETCH;
  endfunction
endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: valid/ready bus between the fetch unit and the unified memory
interface mips_fetch_unit_if #(parameter int N = 32) ();
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_ready;
  logic [N-1:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/mips_fetch_unit_mem_handshake_fsm.sv
// mem_handshake_fsm: IDLE/BUSY memory handshake with latched request, timeout counter and sticky error
module mem_handshake_fsm import mips_fetch_unit_pkg::*; #(
  parameter int N = MFU_N,
  parameter int unsigned TIMEOUT = MFU_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_i,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [N-1:0]      addr_i,
  input  logic [N-1:0]      wdata_i,
  mips_fetch_unit_if.master mem,
  output logic              start_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              err_o,
  output acc_t              acc_o
);
  hs_state_t state_q, state_d;
  acc_t acc_q;
  logic [7:0] cnt_q, cnt_inc;
  logic req_q, we_q, err_q, busy, tout;
  logic [N-1:0] addr_q, wdata_q;
  always_comb begin
    busy = state_q == BUSY;
    start_o = !busy && (fetch_i || load_i || store_i);
    done_o = busy && mem.mem_ready;
    cnt_inc = cnt_q + 8'd1;
    tout = busy && !mem.mem_ready && cnt_inc == 8'(TIMEOUT);
    state_d = start_o ? BUSY : (done_o || tout) ? IDLE : state_q;
    stall_o = start_o || busy;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= ACC_FETCH;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= state_d == BUSY;
      cnt_q <= start_o ? 8'd0 : busy ? cnt_inc : cnt_q;
      err_q <= err_q || tout;
      if (start_o) begin
        acc_q <= acc_sel(store_i, load_i);
        we_q <= store_i;
        addr_q <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  assign mem.mem_req = req_q;
  assign mem.mem_we = we_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign err_o = err_q;
  assign acc_o = acc_q;
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC/IR/MDR registers, next-PC select and IR field decode for the multicycle MIPS core.
// Define INSTR_COUNT_EN to add the instr_count output counting completed fetches.
module mips_fetch_unit import mips_fetch_unit_pkg::*; #(
  parameter int N = MFU_N,
  parameter logic [N-1:0] RESET_PC = N'(MFU_RESET_PC),
  parameter int unsigned TIMEOUT = MFU_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IRWrite,
  input  logic              IorD,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic [1:0]        PCSource,
  input  logic [N-1:0]      alu_result,
  input  logic [N-1:0]      alu_out,
  input  logic              alu_zero,
  input  logic [N-1:0]      reg_b,
  mips_fetch_unit_if.master mem,
  output logic              stall,
  output logic              mem_err,
  output logic [N-1:0]      pc,
  output logic [N-1:0]      ir,
  output logic [N-1:0]      mdr,
  output logic [5:0]        Op_code,
  output logic [5:0]        Funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [N-1:0]      imm_sext
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]       instr_count
`endif
);
  logic [N-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, pend_pc_q, next_pc, jump;
  logic pend_en_q, en, start, done;
  acc_t acc;
  mem_handshake_fsm #(.N(N), .TIMEOUT(TIMEOUT)) u_hs (
    .clk(clk),
    .rst(rst),
    .fetch_i(IRWrite),
    .load_i(MemRead),
    .store_i(MemWrite),
    .addr_i((IorD || MemRead || MemWrite) ? alu_out : pc_q),
    .wdata_i(reg_b),
    .mem(mem),
    .start_o(start),
    .done_o(done),
    .stall_o(stall),
    .err_o(mem_err),
    .acc_o(acc)
  );
  // a PC update requested alongside an access waits for that access to complete
  always_comb begin
    jump = {pc_q[N-1:28], ir_q[25:0], 2'b00};
    en = (PCWrite || (PCWriteCond && alu_zero)) && PCSource != PCSRC_HOLD;
    next_pc = PCSource == PCSRC_ALU ? alu_result :
              PCSource == PCSRC_ALUOUT ? alu_out :
              PCSource == PCSRC_JUMP ? jump : pc_q;
    pc_d = (done && pend_en_q) ? pend_pc_q : (!stall && en) ? next_pc : pc_q;
    ir_d = (done && acc == ACC_FETCH) ? mem.mem_rdata : ir_q;
    mdr_d = (done && acc == ACC_LOAD) ? mem.mem_rdata : mdr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      mdr_q <= '0;
      pend_pc_q <= '0;
      pend_en_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      mdr_q <= mdr_d;
      if (start) begin
        pend_pc_q <= next_pc;
        pend_en_q <= en;
      end
    end
`ifdef INSTR_COUNT_EN
  logic [31:0] icnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) icnt_q <= '0;
    else icnt_q <= icnt_q + 32'(done && acc == ACC_FETCH);
  assign instr_count = icnt_q;
`endif
  assign pc = pc_q;
  assign ir = ir_q;
  assign mdr = mdr_q;
  assign Op_code = ir_q[31:26];
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rd = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign Funct = ir_q[5:0];
  assign imm_sext = {{(N-16){ir_q[15]}}, ir_q[15:0]};
endmodule
